vga_sync_tx: RTL
================

Name: vga_sync_tx

Overview:
- VGA transmitter, the sending end of the hsync/vsync/rgb interface that the racing_game benches capture into 800x525 image matrices.
- Derives a pixel-clock enable from the system clock and runs horizontal and vertical timing counters.
- Publishes the current pixel coordinate to the game logic, registers the returned 3-bit colour, and drives syncs and blanked rgb with matched latency.
- Sits between the game renderer and the FPGA pins. It replaces the ad-hoc timing in the 8bitworkshop wrappers.

Parameters:
- DIV, 2, system clocks per pixel (≥1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525.
- SYNC_POL, 0, sync asserted level (0 = active-low pulses).
- H_TOTAL and V_TOTAL must each be ≤1024.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- pix_en  out  1  one-clk pulse per pixel tick.
- x  out  10  current horizontal count, 0..H_TOTAL-1.
- y  out  10  current vertical count, 0..V_TOTAL-1.
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE.
- frame_start  out  1  pulse on the pix_en tick where x=0, y=0.
- rgb_in  in  3  colour for (x,y), from the renderer; combinational or stable by the pix_en edge.
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- rgb  out  3  registered pixel colour, 0 when blanked.

Behaviour:
- One clock. Reset is asynchronous, active-low (resetn). All state updates on posedge clk.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - pix_en = (div_cnt==DIV-1), registered.
  - DIV=1 gives pix_en constantly high after reset.
- Counters advance only on clocks where pix_en=1.
  - x increments; at H_TOTAL-1 x wraps to 0 and y increments.
  - When x and y are both at their last value (799/524 with defaults), both wrap to 0.
- Derived outputs:
  - active and frame_start are combinational decodes of the x/y registers.
  - frame_start is additionally gated with pix_en.
- Output stage, one pixel of latency. On each pix_en clock:
  - rgb ← active ? rgb_in : 3'b000.
  - hsync ← SYNC_POL when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751 default), else ~SYNC_POL.
  - vsync ← SYNC_POL when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491 default), else ~SYNC_POL.
  - Result: hsync, vsync and rgb all describe the same (x,y), one pixel tick after x/y present it.
- Between pix_en pulses all outputs hold.
- Reset values (immediate, asynchronous):
  - div_cnt=0, pix_en=0, x=0, y=0.
  - rgb=0, hsync=~SYNC_POL, vsync=~SYNC_POL.
  - Hence active=1 and frame_start=0 during reset.
- Reset mid-frame: everything returns to the reset values within the same clock. After release, the first pix_en occurs DIV clocks later with x=0, y=0 and frame_start=1.
- Timing invariants:
  - Line = H_TOTAL pix ticks.
  - Frame = H_TOTAL*V_TOTAL ticks = 420000 ticks = 840000 clks at DIV=2.
- Count widths are 10 bits. No overflow path exists because the counters compare for equality at the TOTAL-1 values.
- rgb_in is ignored on non-pix_en clocks and while blanked.

Test Plan:
- Reset behaviour: hold resetn=0 for 7 clks → rgb=0, hsync=1, vsync=1, x=y=0, pix_en=0. Release → first pix_en on clk 2 (DIV=2) with frame_start=1.
- Horizontal timing, rgb_in tied to 3'b111:
  - hsync goes low on the tick after x=656 and stays low for exactly 96 ticks.
  - Consecutive hsync falling edges are 800 ticks / 1600 clks apart.
  - rgb=7 for 640 ticks per visible line and 0 for 160.
- Vertical timing:
  - vsync low for exactly 2 lines (1600 ticks), starting the tick after (x=0, y=490).
  - frame_start pulses every 420000 ticks.
- Pixel alignment: drive rgb_in = {x[0], y[0], x[1]}, capture 2 frames into an image matrix → every active pixel (i,j) equals that pattern, and all blanking pixels are 0.
- Mid-frame reset: assert resetn=0 at x=300, y=200 for 3 clks → outputs are immediately at their reset values, counting restarts from (0,0), and the next frame has full 800x525 timing.
- DIV=1, SYNC_POL=1: pix_en stays high continuously, hsync is high for 96 clks per 800-clk line, and vsync is high for 1600 clks per frame.

Source files
------------

// File: rtl/vga_sync_tx.sv
// VGA transmitter: pixel-clock enable, horizontal/vertical timing counters,
// coordinate publication to the renderer, and a registered output stage that
// drives hsync, vsync and blanked rgb with one pixel tick of matched latency.
module vga_sync_tx #(
  parameter int DIV      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  input  logic [2:0] rgb_in,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  // Totals must fit the 10-bit counters (each total is at most 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A divide-by-one still needs a 1-bit counter so the logic stays uniform.
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ON    = (SYNC_POL != 0);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en_q,  pix_en_d;
  logic [9:0]    x_q,       x_d;
  logic [9:0]    y_q,       y_d;
  logic [2:0]    rgb_q,     rgb_d;
  logic          hsync_q,   hsync_d;
  logic          vsync_q,   vsync_d;

  logic          active_w;
  logic          in_hsync_w;
  logic          in_vsync_w;

  // Visible-area and sync-window decodes of the current coordinate.
  always_comb begin
    active_w   = (x_q < H_ACT_END) && (y_q < V_ACT_END);
    in_hsync_w = (x_q >= HS_START) && (x_q < HS_END);
    in_vsync_w = (y_q >= VS_START) && (y_q < VS_END);
  end

  // Divider wraps at DIV-1; pix_en is its terminal count, delayed one clock
  // so the first tick after reset lands DIV clocks after release.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    pix_en_d  = (div_cnt_q == DIV_LAST);
  end

  // Timing counters and output stage advance only on pixel ticks; the output
  // registers capture the pixel the counters present during that tick.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      rgb_d   = active_w ? rgb_in : 3'b000;
      hsync_d = in_hsync_w ? SYNC_ON : ~SYNC_ON;
      vsync_d = in_vsync_w ? SYNC_ON : ~SYNC_ON;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= 3'b000;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_w;
  assign frame_start = pix_en_q && (x_q == 10'd0) && (y_q == 10'd0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;

endmodule
